// File: rtl/avmm_burst_reader_if.sv
// Avalon-MM read/write master bus signal set shared by the AVMM blocks.
// master drives requests; slave drives waitrequest and returned read data.
interface avmm_burst_reader_if #(
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 8
);
  logic [AW-1:0]                m_address;
  logic                         m_read;
  logic                         m_write;
  logic [$clog2(MAX_BURST):0]   m_burstcount;
  logic [DW-1:0]                m_writedata;
  logic [DW/8-1:0]              m_byteenable;
  logic                         m_waitrequest;
  logic [DW-1:0]                m_readdata;
  logic                         m_readdatavalid;

  modport master (
    output m_address, m_read, m_write, m_burstcount, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read, m_write, m_burstcount, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/avmm_burst_reader.sv
// AVMM burst read master feeding a FWFT FIFO stream; first m_read 1 cycle after command accept.
// Bursts issue only with FIFO credit for all words in flight, so out_ready backpressure never stalls readdatavalid.
module avmm_burst_reader #(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          busy,
  avmm_burst_reader_if.master m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int BW    = $clog2(MAX_BURST) + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BYTES = DW / 8;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pop_cnt_q, pop_cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] fifo_mem [FIFO_DEPTH];

  logic [BW-1:0] burst;
  logic [CW-1:0] credits;
  logic          issue_ok;
  logic          accept;
  logic          push;
  logic          pop;

  assign burst = (rem_q >= LW'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(rem_q);

  // fifo_cnt + outst never exceeds FIFO_DEPTH, so this cannot underflow.
  assign credits = CW'(FIFO_DEPTH) - fifo_cnt_q - outst_q;

  // Credits only grow while a request is stalled, so m_read is never withdrawn
  // under waitrequest; address and burstcount come straight from flops.
  assign issue_ok = (state_q == ISSUE) && (credits >= CW'(burst));
  assign accept   = issue_ok && !m.m_waitrequest;
  assign push     = m.m_readdatavalid;
  assign pop      = out_valid && out_ready;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = busy_q;

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign out_last  = out_valid && (pop_cnt_q == len_q - LW'(1));

  assign m.m_read       = issue_ok;
  assign m.m_address    = addr_q;
  assign m.m_burstcount = burst;
  assign m.m_write      = 1'b0;
  assign m.m_writedata  = '0;
  assign m.m_byteenable = '1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    pop_cnt_d  = pop_cnt_q;
    busy_d     = busy_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    outst_d    = outst_q - CW'(push) + (accept ? CW'(burst) : '0);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d  = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      pop_cnt_d = pop_cnt_q + LW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_len != '0)) begin
          addr_d    = cmd_addr & ALIGN_MASK;
          rem_d     = cmd_len;
          len_d     = cmd_len;
          pop_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          rem_d  = rem_q - LW'(burst);
          addr_d = addr_q + AW'(burst) * AW'(BYTES);
          if (rem_q == LW'(burst)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && ((pop_cnt_q == len_q) || (pop && out_last))) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
    end
  end

  // Storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= m.m_readdata;
    end
  end

endmodule

// File: tb/tb_avmm_burst_reader.sv
// Bench for avmm_burst_reader: slave model, command-level reference model, table and random commands.
module tb_avmm_burst_reader;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MB = 8;
  localparam int FD = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  avmm_burst_reader_if #(.AW(AW), .DW(DW), .MAX_BURST(MB)) bus ();

  avmm_burst_reader #(.AW(AW), .DW(DW), .MAX_BURST(MB), .FIFO_DEPTH(FD), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .m         (bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  cnt;
  } burst_t;

  typedef struct {
    logic [63:0] dat;
    bit          last;
  } word_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    int          wpct;
    int          rpct;
    int          exp_nb;
    logic [15:0] exp_first;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int wait_pct, rdy_pct, rdv_pct;
  int force_idx, force_left;
  int n_acc, n_words, n_last, n_stall;
  int issued, popped;
  logic [15:0] first_addr;
  bit          prev_stall;
  logic [15:0] prev_addr;
  logic [3:0]  prev_bc;

  burst_t      exp_bursts[$];
  word_t       exp_words[$];
  logic [15:0] resp_q[$];
  vec_t        vecs[5];

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {16'hD00D, a, ~a, a ^ 16'h5A5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave and stream monitor, evaluated on the falling edge for the coming rising edge.
  task automatic monitor_step();
    burst_t eb;
    word_t  ew;
    logic [15:0] a;
    if (!rst_n) begin
      bus.m_waitrequest   = 1'b0;
      bus.m_readdatavalid = 1'b0;
      resp_q.delete();
      exp_bursts.delete();
      exp_words.delete();
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("stall_read", bus.m_read, 1);
      check("stall_addr", bus.m_address, prev_addr);
      check("stall_bc", bus.m_burstcount, prev_bc);
    end
    if (resp_q.size() > 0 && $urandom_range(0, 99) < rdv_pct) begin
      a = resp_q.pop_front();
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata      = mem_word(a);
    end else begin
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata      = '0;
    end
    if (bus.m_read && n_acc == force_idx && force_left > 0) begin
      bus.m_waitrequest = 1'b1;
      force_left--;
    end else begin
      bus.m_waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
    out_ready  = ($urandom_range(0, 99) < rdy_pct);
    prev_stall = bus.m_read && bus.m_waitrequest;
    prev_addr  = bus.m_address;
    prev_bc    = bus.m_burstcount;
    if (prev_stall) n_stall++;
    if (bus.m_read && !bus.m_waitrequest) begin
      if (n_acc == 0) first_addr = bus.m_address;
      n_acc++;
      issued += int'(bus.m_burstcount);
      check("burst_expected", exp_bursts.size() != 0, 1);
      if (exp_bursts.size() != 0) begin
        eb = exp_bursts.pop_front();
        check("burst_addr", bus.m_address, eb.addr);
        check("burst_cnt", bus.m_burstcount, eb.cnt);
      end
      check("credit_room", (issued - popped) <= FD, 1);
      for (int j = 0; j < int'(bus.m_burstcount); j++) begin
        a = bus.m_address + 16'(8 * j);
        resp_q.push_back(a);
      end
    end
    if (out_valid && out_ready) begin
      popped++;
      n_words++;
      if (out_last) n_last++;
      check("word_expected", exp_words.size() != 0, 1);
      if (exp_words.size() != 0) begin
        ew = exp_words.pop_front();
        check("out_data", out_data, ew.dat);
        check("out_last", out_last, ew.last);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #2;
  endtask

  // Reference: aligned base, bursts of min(remaining, MB), word k at base + 8k mod 2^16.
  task automatic run_cmd(input logic [15:0] addr, input logic [15:0] len);
    logic [15:0] a0, a;
    int rem, c;
    burst_t b;
    word_t  w;
    a0  = addr & 16'hFFF8;
    a   = a0;
    rem = int'(len);
    while (rem > 0) begin
      c = (rem > MB) ? MB : rem;
      b.addr = a;
      b.cnt  = 4'(c);
      exp_bursts.push_back(b);
      a   = a + 16'(c * 8);
      rem = rem - c;
    end
    for (int k = 0; k < int'(len); k++) begin
      a      = a0 + 16'(8 * k);
      w.dat  = mem_word(a);
      w.last = (k == int'(len) - 1);
      exp_words.push_back(w);
    end
    n_acc = 0; n_words = 0; n_last = 0; n_stall = 0;
    first_addr = 16'hXXXX;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while ((busy || exp_words.size() != 0 || exp_bursts.size() != 0) && t < budget) begin
      tick();
      t++;
    end
    check({name, "_done"}, t < budget, 1);
    repeat (4) tick();
  endtask

  initial begin
    vecs[0] = '{16'h0100,  8,  0, 100, 1, 16'h0100};
    vecs[1] = '{16'h0000, 20,  0, 100, 3, 16'h0000};
    vecs[2] = '{16'h0103,  5,  0, 100, 1, 16'h0100};
    vecs[3] = '{16'hFFC0, 16,  0, 100, 2, 16'hFFC0};
    vecs[4] = '{16'h1238, 17, 30,  60, 3, 16'h1238};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    bus.m_waitrequest = 1'b0; bus.m_readdatavalid = 1'b0; bus.m_readdata = '0;
    wait_pct = 0; rdy_pct = 100; rdv_pct = 100; force_idx = -1; force_left = 0;
    issued = 0; popped = 0; prev_stall = 1'b0;
    n_acc = 0; n_words = 0; n_last = 0; n_stall = 0; first_addr = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_m_read", bus.m_read, 0);
    check("rst_m_address", bus.m_address, 0);
    check("rst_m_burstcount", bus.m_burstcount, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_m_write", bus.m_write, 0);
    check("rst_byteenable", bus.m_byteenable, 8'hFF);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      wait_pct = vecs[i].wpct;
      rdy_pct  = vecs[i].rpct;
      run_cmd(vecs[i].addr, vecs[i].len);
      check("vec_busy_set", busy, 1);
      check("vec_cmd_ready_low", cmd_ready, 0);
      check("vec_first_read_latency", bus.m_read, 1);
      wait_done("vec", 2000);
      check("vec_nbursts", n_acc, vecs[i].exp_nb);
      check("vec_first_addr", first_addr, vecs[i].exp_first);
      check("vec_nwords", n_words, vecs[i].len);
      check("vec_nlast", n_last, 1);
      check("vec_busy_clear", busy, 0);
    end

    wait_pct = 0; rdy_pct = 100;
    run_cmd(16'h0300, 16'd0);
    check("len0_busy", busy, 0);
    check("len0_cmd_ready", cmd_ready, 1);
    repeat (10) tick();
    check("len0_no_read", n_acc, 0);
    check("len0_cmd_ready_held", cmd_ready, 1);

    force_idx = 1; force_left = 5;
    run_cmd(16'h0000, 16'd20);
    wait_done("wait", 2000);
    check("wait_nbursts", n_acc, 3);
    check("wait_stalls", n_stall, 5);
    check("wait_nwords", n_words, 20);
    force_idx = -1;

    rdy_pct = 0;
    run_cmd(16'h0200, 16'd40);
    repeat (60) tick();
    check("bp_nbursts", n_acc, 2);
    check("bp_read_idle", bus.m_read, 0);
    check("bp_out_valid", out_valid, 1);
    rdy_pct = 100;
    wait_done("bp", 2000);
    check("bp_nbursts_total", n_acc, 5);
    check("bp_nwords", n_words, 40);
    check("bp_nlast", n_last, 1);

    for (int r = 0; r < 10; r++) begin
      logic [15:0] ra, rl;
      ra = 16'($urandom);
      rl = 16'($urandom_range(1, 40));
      wait_pct = $urandom_range(0, 50);
      rdy_pct  = $urandom_range(20, 100);
      rdv_pct  = $urandom_range(50, 100);
      run_cmd(ra, rl);
      wait_done("rand", 3000);
      check("rand_nwords", n_words, rl);
      check("rand_nlast", n_last, 1);
      check("rand_nbursts", n_acc, (int'(rl) + MB - 1) / MB);
    end

    wait_pct = 0; rdy_pct = 0; rdv_pct = 100;
    run_cmd(16'h0400, 16'd40);
    repeat (4) tick();
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_m_read", bus.m_read, 0);
    check("mid_m_address", bus.m_address, 0);
    check("mid_m_burstcount", bus.m_burstcount, 0);
    check("mid_busy", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_last", out_last, 0);
    check("mid_out_data", out_data, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    repeat (2) tick();
    issued = 0; popped = 0;
    rst_n = 1'b1;
    tick();
    check("post_cmd_ready", cmd_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
    rdy_pct = 100;
    run_cmd(16'h0100, 16'd8);
    wait_done("post", 2000);
    check("post_nwords", n_words, 8);
    check("post_nlast", n_last, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
